// File: rtl/shift_dispatch_arbiter.sv
// Round-robin dispatcher of shift-class commands from four ports into a one-entry issue register,
// with per-tag busy tracking and a drain/quiesce FSM. Optional counters: SHIFT_DISPATCH_STATS_EN.
module shift_dispatch_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RR_RESET_PORT   = 0
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [15:0] req_cmd,
  input  logic [7:0]  req_tag,
  output logic [3:0]  req_ready,
  output logic        shift_issue_valid,
  output logic [3:0]  shift_out_cmd,
  output logic [3:0]  shift_tag,
  input  logic        shift_ready,
  input  logic [7:0]  cmpl_resp,
  input  logic [7:0]  cmpl_tag,
  input  logic        drain_req,
  output logic        drain_done,
  output logic [4:0]  outstanding,
  output logic        err_bad_cmd,
  output logic        err_cmpl
`ifdef SHIFT_DISPATCH_STATS_EN
  ,
  output logic [63:0] stat_grants,
  input  logic        stat_clear
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] busy_q, busy_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic        issue_valid_q, issue_valid_d;
  logic [3:0]  issue_cmd_q, issue_cmd_d;
  logic [3:0]  issue_tag_q, issue_tag_d;
  logic [4:0]  outstanding_q, outstanding_d;
  logic        err_bad_cmd_q, err_bad_cmd_d;
  logic        err_cmpl_q, err_cmpl_d;
  logic        drain_done_q, drain_done_d;

  logic        can_load, has_room;
  logic [3:0]  eligible, grant;
  logic [1:0]  grant_port, scan_port;
  logic        grant_any, acc_valid;
  logic [3:0]  acc_cmd, acc_tag, cmpl_idx;
  logic [2:0]  ncompl;
  logic        cmpl_bad;
  int          count_next;

  function automatic logic cmd_is_valid(input logic [3:0] cmd);
    return cmd inside {4'b0101, 4'b0110, 4'b1001, 4'b1010};
  endfunction

  // An invalid command bypasses the busy/count gates: it is swallowed without taking a slot.
  always_comb begin
    can_load = (state_q == ST_RUN) && !drain_req && (!issue_valid_q || shift_ready);
    has_room = int'(outstanding_q) < MAX_OUTSTANDING;
    for (int p = 0; p < 4; p++) begin
      eligible[p] = req_valid[p] && can_load &&
                    (!cmd_is_valid(req_cmd[4*p +: 4]) ||
                     (!busy_q[{2'(p), req_tag[2*p +: 2]}] && has_room));
    end
  end

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant      = '0;
    grant_port = rr_ptr_q;
    grant_any  = 1'b0;
    scan_port  = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_port = rr_ptr_q + 2'(k);
      if (!grant_any && eligible[scan_port]) begin
        grant[scan_port] = 1'b1;
        grant_port       = scan_port;
        grant_any        = 1'b1;
      end
    end
  end

  assign acc_cmd   = req_cmd[{grant_port, 2'b00} +: 4];
  assign acc_tag   = {grant_port, req_tag[{grant_port, 1'b0} +: 2]};
  assign acc_valid = grant_any && cmd_is_valid(acc_cmd);

  always_comb begin
    busy_d   = busy_q;
    ncompl   = '0;
    cmpl_bad = 1'b0;
    cmpl_idx = '0;
    for (int q = 0; q < 4; q++) begin
      cmpl_idx = {2'(q), cmpl_tag[2*q +: 2]};
      if (cmpl_resp[2*q +: 2] != 2'b00) begin
        if (busy_q[cmpl_idx]) begin
          busy_d[cmpl_idx] = 1'b0;
          ncompl           = ncompl + 3'd1;
        end else begin
          cmpl_bad = 1'b1;
        end
      end
    end
    // A tag freed this cycle was not eligible this cycle, so set-after-clear cannot collide.
    if (acc_valid) busy_d[acc_tag] = 1'b1;

    count_next = int'(outstanding_q) + int'(acc_valid) - int'(ncompl);
    if (count_next > MAX_OUTSTANDING) count_next = MAX_OUTSTANDING;
    else if (count_next < 0)          count_next = 0;
    outstanding_d = 5'(count_next);

    issue_valid_d = issue_valid_q && !shift_ready;
    issue_cmd_d   = issue_cmd_q;
    issue_tag_d   = issue_tag_q;
    if (acc_valid) begin
      issue_valid_d = 1'b1;
      issue_cmd_d   = acc_cmd;
      issue_tag_d   = acc_tag;
    end

    rr_ptr_d      = grant_any ? grant_port + 2'd1 : rr_ptr_q;
    err_bad_cmd_d = grant_any && !acc_valid;
    err_cmpl_d    = err_cmpl_q || cmpl_bad;

    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req)                                   state_d = ST_RUN;
        else if (!issue_valid_q && outstanding_q == 5'd0) state_d = ST_DONE;
      end
      ST_DONE:  if (!drain_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    drain_done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      // NOTE: busy is a small flop vector, not a RAM, so it is reset along with everything else.
      busy_q        <= '0;
      rr_ptr_q      <= 2'(RR_RESET_PORT);
      issue_valid_q <= 1'b0;
      issue_cmd_q   <= '0;
      issue_tag_q   <= '0;
      outstanding_q <= '0;
      err_bad_cmd_q <= 1'b0;
      err_cmpl_q    <= 1'b0;
      drain_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_cmd_q   <= issue_cmd_d;
      issue_tag_q   <= issue_tag_d;
      outstanding_q <= outstanding_d;
      err_bad_cmd_q <= err_bad_cmd_d;
      err_cmpl_q    <= err_cmpl_d;
      drain_done_q  <= drain_done_d;
    end
  end

  assign req_ready         = grant;
  assign shift_issue_valid = issue_valid_q;
  assign shift_out_cmd     = issue_cmd_q;
  assign shift_tag         = issue_tag_q;
  assign outstanding       = outstanding_q;
  assign err_bad_cmd       = err_bad_cmd_q;
  assign err_cmpl          = err_cmpl_q;
  assign drain_done        = drain_done_q;

`ifdef SHIFT_DISPATCH_STATS_EN
  logic [3:0][15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (stat_clear)     stat_d = '0;
    else if (acc_valid) stat_d[grant_port] = stat_q[grant_port] + 16'd1;
  end

  always_ff @(posedge c_clk) begin
    if (!reset) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_grants = stat_q;
`endif

endmodule

// File: tb/tb_shift_dispatch_arbiter.sv
// Randomized scoreboard bench for shift_dispatch_arbiter: a tag-set reference model predicts grants,
// counts and flags; issued commands are queued and matched by an independent monitor.
module tb_shift_dispatch_arbiter;

  localparam int MAX = 4;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_cmd;
  logic [7:0]  req_tag;
  logic [3:0]  req_ready;
  logic        shift_issue_valid;
  logic [3:0]  shift_out_cmd;
  logic [3:0]  shift_tag;
  logic        shift_ready;
  logic [7:0]  cmpl_resp;
  logic [7:0]  cmpl_tag;
  logic        drain_req;
  logic        drain_done;
  logic [4:0]  outstanding;
  logic        err_bad_cmd;
  logic        err_cmpl;

  shift_dispatch_arbiter #(.MAX_OUTSTANDING(MAX), .RR_RESET_PORT(0)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_tag(req_tag), .req_ready(req_ready),
    .shift_issue_valid(shift_issue_valid), .shift_out_cmd(shift_out_cmd), .shift_tag(shift_tag),
    .shift_ready(shift_ready), .cmpl_resp(cmpl_resp), .cmpl_tag(cmpl_tag),
    .drain_req(drain_req), .drain_done(drain_done), .outstanding(outstanding),
    .err_bad_cmd(err_bad_cmd), .err_cmpl(err_cmpl)
  );

  always #5 c_clk = ~c_clk;

  typedef struct packed {
    logic [3:0] cmd;
    logic [3:0] tag;
  } issue_t;

  // Reference model: set of in-flight {port,tag}, next port in line, issue slot occupancy, drain mode.
  bit     m_busy[16];
  int     m_rr;
  int     m_mode;          // 0 accepting, 1 draining, 2 drained
  bit     m_full;
  bit     e_bad, e_cerr, e_done;
  bit     after_reset;
  issue_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] legal_cmds[4] = '{4'b0101, 4'b0110, 4'b1001, 4'b1010};

  function automatic bit cmd_legal(input logic [3:0] c);
    return (c == 4'b0101) || (c == 4'b0110) || (c == 4'b1001) || (c == 4'b1010);
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle, entered just after a falling edge.
  task automatic step(input bit rst, input logic [3:0] v, input logic [15:0] cmd,
                      input logic [7:0] tg, input logic sr, input logic [7:0] cr,
                      input logic [7:0] ct, input logic dr);
    int  g, p, t, old_cnt;
    bit  found, old_full;
    logic [3:0] c;
    logic [1:0] tag;

    check("outstanding", 64'(outstanding), 64'(busy_count()));
    check("issue_valid", 64'(shift_issue_valid), 64'(m_full));
    check("err_bad_cmd", 64'(err_bad_cmd), 64'(e_bad));
    check("err_cmpl", 64'(err_cmpl), 64'(e_cerr));
    check("drain_done", 64'(drain_done), 64'(e_done));
    if (after_reset) check("reset_issue_regs", 64'({shift_out_cmd, shift_tag}), 64'd0);

    reset       = !rst;
    req_valid   = v;
    req_cmd     = cmd;
    req_tag     = tg;
    shift_ready = sr;
    cmpl_resp   = cr;
    cmpl_tag    = ct;
    drain_req   = dr;
    #1;

    found = 1'b0;
    g     = 0;
    if (!rst && m_mode == 0 && !dr && (!m_full || sr)) begin
      for (int k = 0; k < 4; k++) begin
        p   = (m_rr + k) % 4;
        c   = cmd[4*p +: 4];
        tag = tg[2*p +: 2];
        if (!found && v[p] && (!cmd_legal(c) || (!m_busy[p*4 + int'(tag)] && busy_count() < MAX))) begin
          found = 1'b1;
          g     = p;
        end
      end
    end
    if (!rst) check("req_ready", 64'(req_ready), found ? 64'(1) << g : 64'd0);

    if (rst) begin
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      m_rr = 0; m_mode = 0; m_full = 1'b0;
      e_bad = 1'b0; e_cerr = 1'b0; e_done = 1'b0;
      sb_q.delete();
      after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      old_full    = m_full;
      old_cnt     = busy_count();
      e_bad       = 1'b0;
      for (int q = 0; q < 4; q++) begin
        if (cr[2*q +: 2] != 2'b00) begin
          t = q*4 + int'(ct[2*q +: 2]);
          if (m_busy[t]) m_busy[t] = 1'b0;
          else           e_cerr    = 1'b1;
        end
      end
      m_full = old_full && !sr;
      if (found) begin
        m_rr = (g + 1) % 4;
        c    = cmd[4*g +: 4];
        tag  = tg[2*g +: 2];
        if (cmd_legal(c)) begin
          m_busy[g*4 + int'(tag)] = 1'b1;
          sb_q.push_back('{cmd: c, tag: {2'(g), tag}});
          m_full = 1'b1;
        end else begin
          e_bad = 1'b1;
        end
      end
      case (m_mode)
        0: if (dr) m_mode = 1;
        1: if (!dr) m_mode = 0; else if (!old_full && old_cnt == 0) m_mode = 2;
        default: if (!dr) m_mode = 0;
      endcase
      e_done = (m_mode == 2);
    end
    @(negedge c_clk);
  endtask

  // Monitor: every issue handshake must deliver the oldest accepted command.
  initial begin
    issue_t exp_issue;
    forever begin
      @(negedge c_clk);
      #2;
      if (reset && shift_issue_valid && shift_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL issue_unexpected: got %0h expected nothing at %0t",
                   {shift_out_cmd, shift_tag}, $time);
        end else begin
          exp_issue = sb_q.pop_front();
          check("issue_cmd_tag", 64'({shift_out_cmd, shift_tag}), 64'(exp_issue));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  v;
    logic [15:0] cmd;
    logic [7:0]  tg, cr, ct;
    logic        sr, dr, rst;
    int          drain_left;
    int          opts[$];

    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    m_rr = 0; m_mode = 0; m_full = 1'b0;
    e_bad = 1'b0; e_cerr = 1'b0; e_done = 1'b0; after_reset = 1'b0;
    drain_left = 0;

    reset = 1'b0; req_valid = '0; req_cmd = '0; req_tag = '0;
    shift_ready = 1'b0; cmpl_resp = '0; cmpl_tag = '0; drain_req = 1'b0;
    repeat (2) @(negedge c_clk);

    step(1'b1, 4'h0, 16'h0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0);
    // All four ports with cmd 0101 tag 0: rotation 1,2,3,4 then the count limit stalls the fifth.
    repeat (6) step(1'b0, 4'hF, 16'h5555, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      v   = 4'($urandom);
      tg  = 8'($urandom);
      for (int p = 0; p < 4; p++)
        cmd[4*p +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_cmds[$urandom_range(0, 3)];
      sr = ($urandom_range(0, 3) != 0);
      cr = '0;
      ct = 8'($urandom);
      for (int q = 0; q < 4; q++) begin
        if (cyc > 2400 && $urandom_range(0, 19) == 0) begin
          cr[2*q +: 2] = 2'($urandom_range(1, 3));
        end else if ($urandom_range(0, 3) == 0) begin
          opts.delete();
          for (int t = 0; t < 4; t++) if (m_busy[q*4 + t]) opts.push_back(t);
          if (opts.size() > 0) begin
            ct[2*q +: 2] = 2'(opts[$urandom_range(0, opts.size() - 1)]);
            cr[2*q +: 2] = 2'($urandom_range(1, 3));
          end
        end
      end
      if (drain_left > 0) drain_left--;
      else if ($urandom_range(0, 79) == 0) drain_left = $urandom_range(5, 40);
      dr = (drain_left > 0);
      step(rst, v, cmd, tg, sr, cr, ct, dr);
    end

    repeat (3) step(1'b0, 4'h0, 16'h0, 8'h0, 1'b1, 8'h0, 8'h0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_dispatch_arbiter.md
Name: shift_dispatch_arbiter

Overview:
- Front-end scheduler for the shifter pipeline.
- Arbitrates shift-class commands (0101, 0110, 1001, 1010) from the four requester ports with round-robin priority and issues one command per handshake to the shifter, with a 4-bit tag {port[0:1], tag[0:1]}.
- Tracks every outstanding tag until the shifter output stage returns a response on shift_out_resp1..4.
- Supports a drain/quiesce sequence for flush.

Parameters:
- MAX_OUTSTANDING, 4: maximum commands accepted but not yet completed, across all ports (legal 1..16).
- RR_RESET_PORT, 0: port index (0..3) given highest priority after reset.

Ports:
- c_clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; 0 sampled at a clock edge resets all state.
- req_valid  input  4  bit i = port i+1 has a command.
- req_cmd  input  16  port i command at [4i:4i+3].
- req_tag  input  8  port i tag at [2i:2i+1].
- req_ready  output  4  bit i = port i+1 command accepted this cycle.
- shift_issue_valid  output  1  issue register holds a command.
- shift_out_cmd  output  4  issued command.
- shift_tag  output  4  {port, tag} of the issued command.
- shift_ready  input  1  shifter accepts the issue this cycle.
- cmpl_resp  input  8  shift_out_resp1..4 concatenated, port1 at [0:1].
- cmpl_tag  input  8  shift_out_tag1..4 concatenated.
- drain_req  input  1  stop accepting new commands.
- drain_done  output  1  pipeline empty while drain is held.
- outstanding  output  5  count of accepted, uncompleted commands.
- err_bad_cmd  output  1  one-cycle pulse: an invalid command was accepted and dropped.
- err_cmpl  output  1  sticky: a completion arrived for a tag that was not busy.

Behaviour:
- Reset values (reset=0 at an edge): all outputs 0, busy[0:15] cleared, issue register empty, rr_ptr=RR_RESET_PORT, FSM in RUN. A command held in the issue register during reset is discarded; shift_issue_valid is 0 in the cycle after the reset edge.
- Eligibility: port p is eligible when all of the following hold.
  - req_valid[p]=1.
  - busy[{p,req_tag_p}]=0.
  - outstanding < MAX_OUTSTANDING.
  - FSM=RUN and drain_req=0.
  - The issue register is empty, or shift_ready=1 this cycle.
- Invalid commands: a port presenting an invalid command is eligible regardless of busy or count. It is accepted and dropped, pulses err_bad_cmd, and takes no slot.
- Grant:
  - Round-robin grant, combinational. Search starts at rr_ptr. At most one req_ready bit is high per cycle.
  - After a grant to port p, rr_ptr <= (p+1) mod 4. With no grant, rr_ptr holds.
- Accept (req_valid & req_ready), valid command:
  - busy[{p,tag}] <= 1.
  - outstanding += 1.
  - The command is loaded into the issue register, and shift_issue_valid=1 the next cycle (1-cycle latency).
- Issue handshake: shift_issue_valid & shift_ready empties the register. Back-to-back issue is possible: accept and handshake in the same cycle keeps the register full with the new command.
- Issue stability: while shift_issue_valid=1 and shift_ready=0, shift_out_cmd and shift_tag hold stable.
- Completion: for each port q with cmpl_resp_q != 00, clear busy[{q, cmpl_tag_q}] and subtract 1 from outstanding. Up to 4 completions per cycle.
- Completion for a tag that is not busy: no count change; err_cmpl <= 1 until reset.
- Same-cycle events:
  - Accept and completions in one cycle: outstanding <= outstanding + 1 - ncompl.
  - A completion that frees a tag makes that tag eligible the next cycle, not the same cycle.
- FSM states:
  - RUN: granting enabled. drain_req=1 -> DRAIN; req_ready is forced to 0 in the same cycle drain_req rises.
  - DRAIN: no grants. When the issue register is empty and outstanding=0 -> DONE. If drain_req falls -> RUN.
  - DONE: drain_done=1. When drain_req falls -> RUN (drain_done=0 next cycle).
- Counter saturation: outstanding never exceeds MAX_OUTSTANDING and never underflows.

Optional Feature:
- Macro: SHIFT_DISPATCH_STATS_EN.
- Defined: adds output stat_grants (64 bits), four 16-bit per-port accepted-command counters, port1 at [0:15]. Each counter increments on every accepted valid command for its port, wraps 0xFFFF -> 0, and clears on reset. Adds input stat_clear (1 bit), which zeroes all four counters on the next edge; stat_clear takes priority over an increment in the same cycle.
- Undefined: neither port exists; no counters are built.

Test Plan:
- Reset release; all four ports valid with cmd 0101, tags 0, shift_ready=1 -> grants in order port1, 2, 3, 4 on consecutive cycles; shift_tag 0000, 0100, 1000, 1100; outstanding reaches 4; a fifth request waits.
- Port2 issues tag 01 and re-requests tag 01 -> req_ready[1]=0 until cmpl_resp2=01 with cmpl_tag2=01; accepted the cycle after the completion.
- shift_ready held 0 for 3 cycles with cmd 1010 tag 0110 in the issue register -> shift_issue_valid, shift_out_cmd and shift_tag stable; no further req_ready.
- Port3 presents cmd 0011 -> accepted, err_bad_cmd pulses for 1 cycle, no issue, outstanding unchanged.
- drain_req=1 with 2 outstanding -> req_ready=0 immediately; drain_done=1 one cycle after the second completion; drain_req=0 -> granting resumes.
- reset=0 while the issue register is full and outstanding=3 -> next cycle all outputs 0, busy cleared; completion for a pre-reset tag sets err_cmpl.
